// File: rtl/ahb_dp_sel.sv
// AHB data-phase select register with a built-in default slave.
// The address-phase decoder select is registered into a data-phase select
// for the response mux. Decode misses and conflicts are routed to an internal
// default slave, which gives a two-cycle ERROR response to real transfers.
module ahb_dp_sel #(
    parameter int NS = 10,
    parameter int CW = 8
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic [1:0]    htrans,
    input  logic          hready,
    input  logic [NS-1:0] hsel_ap,
    output logic [NS-1:0] dsel,
    output logic          dflt_sel,
    output logic          dflt_hreadyout,
    output logic          dflt_hresp,
    output logic [CW-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state;
    logic          fsm_hreadyout;
    logic          fsm_hresp;
    logic          sel_any;
    logic          sel_multi;
    logic          sel_valid;
    logic          err_req;
    logic          capture;
    logic [CW-1:0] cnt_inc;

    // Classify the address-phase select: one-hot is a valid decode, anything
    // else goes to the default slave; only real transfers get an ERROR.
    // ERR1 never captures, even if the fed-back hready is wrongly high.
    always_comb begin
        sel_any   = |hsel_ap;
        sel_multi = |(hsel_ap & (hsel_ap - NS'(1)));
        sel_valid = sel_any & ~sel_multi;
        err_req   = ~sel_valid & htrans[1];
        capture   = hready & (state != ERR1);
        cnt_inc   = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CW'(1);
    end

    // Register the data-phase select on each accepted address phase.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel     <= '0;
            dflt_sel <= 1'b1;
        end else if (capture) begin
            dsel     <= sel_valid ? hsel_ap : '0;
            dflt_sel <= ~sel_valid;
        end
    end

    // Default-slave FSM with registered response outputs and saturating error counter.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state         <= IDLE;
            fsm_hreadyout <= 1'b1;
            fsm_hresp     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture && err_req) begin
                        state         <= ERR1;
                        fsm_hreadyout <= 1'b0;
                        fsm_hresp     <= 1'b1;
                        err_cnt       <= cnt_inc;
                    end
                end
                ERR1: begin
                    state         <= ERR2;
                    fsm_hreadyout <= 1'b1;
                    fsm_hresp     <= 1'b1;
                end
                ERR2: begin
                    if (capture) begin
                        if (err_req) begin
                            state         <= ERR1;
                            fsm_hreadyout <= 1'b0;
                            fsm_hresp     <= 1'b1;
                            err_cnt       <= cnt_inc;
                        end else begin
                            state         <= IDLE;
                            fsm_hreadyout <= 1'b1;
                            fsm_hresp     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    fsm_hreadyout <= 1'b1;
                    fsm_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // The default slave only drives the bus response when it owns the data phase.
    always_comb begin
        dflt_hreadyout = fsm_hreadyout & dflt_sel;
        dflt_hresp     = fsm_hresp & dflt_sel;
    end

endmodule

// File: tb/tb_ahb_dp_sel.sv
// Directed testbench for ahb_dp_sel: one task per scenario, each with
// hand-computed expected vectors {dsel, dflt_sel, dflt_hreadyout, dflt_hresp, err_cnt}.
module tb_ahb_dp_sel;

    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [1:0] htrans = 2'b00;
    logic       hready = 1'b1;
    logic [9:0] hsel_ap = '0;

    logic [9:0] dsel;
    logic       dflt_sel;
    logic       dflt_hreadyout;
    logic       dflt_hresp;
    logic [7:0] err_cnt;

    logic [9:0] s_dsel;
    logic       s_dflt_sel;
    logic       s_dflt_hreadyout;
    logic       s_dflt_hresp;
    logic [1:0] s_err_cnt;

    logic [20:0] obs;
    int vectors = 0;
    int miscompares = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ = 2'b11;
    // {dflt_sel, dflt_hreadyout, dflt_hresp} as seen in each default-slave state
    localparam logic [2:0] D_IDLE = 3'b110;
    localparam logic [2:0] D_ERR1 = 3'b101;
    localparam logic [2:0] D_ERR2 = 3'b111;
    localparam logic [2:0] D_SLV  = 3'b000;

    ahb_dp_sel #(.NS(10), .CW(8)) dut (
        .hclk(hclk), .hreset(hreset), .htrans(htrans), .hready(hready),
        .hsel_ap(hsel_ap), .dsel(dsel), .dflt_sel(dflt_sel),
        .dflt_hreadyout(dflt_hreadyout), .dflt_hresp(dflt_hresp), .err_cnt(err_cnt)
    );

    ahb_dp_sel #(.NS(10), .CW(2)) dut_sat (
        .hclk(hclk), .hreset(hreset), .htrans(htrans), .hready(hready),
        .hsel_ap(hsel_ap), .dsel(s_dsel), .dflt_sel(s_dflt_sel),
        .dflt_hreadyout(s_dflt_hreadyout), .dflt_hresp(s_dflt_hresp), .err_cnt(s_err_cnt)
    );

    assign obs = {dsel, dflt_sel, dflt_hreadyout, dflt_hresp, err_cnt};

    // Free-running bus clock
    always #5 hclk = ~hclk;

    task automatic applyStimulus(input logic rst, input logic [9:0] hs,
                                 input logic [1:0] ht, input logic hr);
        hreset  = rst;
        hsel_ap = hs;
        htrans  = ht;
        hready  = hr;
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] exp;
        applyStimulus(1'b1, 10'b0000000011, T_NONSEQ, 1'b1);
        tick();
        exp = {10'h000, D_IDLE, 8'd0};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL reset: got %h want %h", obs, exp); end
    endtask

    task automatic test_valid_decode();
        logic [20:0] exp;
        applyStimulus(1'b0, 10'b0000001000, T_NONSEQ, 1'b1);
        tick();
        exp = {10'b0000001000, D_SLV, 8'd0};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL valid_nonseq: got %h want %h", obs, exp); end
        applyStimulus(1'b0, 10'b1000000000, T_IDLE, 1'b1);
        tick();
        exp = {10'b1000000000, D_SLV, 8'd0};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL valid_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_miss_error();
        logic [20:0] exp;
        applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b1);
        tick();
        exp = {10'h000, D_ERR1, 8'd1};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL miss_err1: got %h want %h", obs, exp); end
        // master changes htrans during ERR1; nothing may be captured
        applyStimulus(1'b0, 10'b0000000100, T_IDLE, 1'b0);
        tick();
        exp = {10'h000, D_ERR2, 8'd1};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL miss_err2: got %h want %h", obs, exp); end
        applyStimulus(1'b0, 10'b0000000100, T_NONSEQ, 1'b1);
        tick();
        exp = {10'b0000000100, D_SLV, 8'd1};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL miss_after: got %h want %h", obs, exp); end
    endtask

    task automatic test_conflict();
        logic [20:0] exp;
        applyStimulus(1'b0, 10'b0000000011, T_SEQ, 1'b1);
        tick();
        exp = {10'h000, D_ERR1, 8'd2};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL conflict_err1: got %h want %h", obs, exp); end
        applyStimulus(1'b0, 10'b0000000011, T_SEQ, 1'b0);
        tick();
        exp = {10'h000, D_ERR2, 8'd2};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL conflict_err2: got %h want %h", obs, exp); end
        applyStimulus(1'b0, 10'h000, T_IDLE, 1'b1);
        tick();
        exp = {10'h000, D_IDLE, 8'd2};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL miss_idle_okay: got %h want %h", obs, exp); end
    endtask

    task automatic test_hold();
        logic [20:0] exp;
        logic [9:0] held [3];
        held[0] = 10'b1000000000;
        held[1] = 10'b0000000000;
        held[2] = 10'b1000000000;
        applyStimulus(1'b0, 10'b0000000001, T_NONSEQ, 1'b1);
        tick();
        exp = {10'b0000000001, D_SLV, 8'd2};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL hold_load: got %h want %h", obs, exp); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, held[i], T_NONSEQ, 1'b0);
            tick();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("[TB] FAIL hold_wait%0d: got %h want %h", i, obs, exp); end
        end
        applyStimulus(1'b0, 10'b1000000000, T_NONSEQ, 1'b1);
        tick();
        exp = {10'b1000000000, D_SLV, 8'd2};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL hold_release: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp;
        applyStimulus(1'b1, 10'h000, T_IDLE, 1'b1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b1);
            tick();
            exp = {10'h000, D_ERR1, 8'(i)};
            vectors++;
            if (obs !== exp) begin miscompares++; $display("[TB] FAIL b2b_err1_%0d: got %h want %h", i, obs, exp); end
            applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b0);
            tick();
            exp = {10'h000, D_ERR2, 8'(i)};
            vectors++;
            if (obs !== exp) begin miscompares++; $display("[TB] FAIL b2b_err2_%0d: got %h want %h", i, obs, exp); end
        end
        applyStimulus(1'b0, 10'h000, T_IDLE, 1'b1);
        tick();
        exp = {10'h000, D_IDLE, 8'd3};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL b2b_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        logic [7:0] exp_cnt;
        applyStimulus(1'b1, 10'h000, T_IDLE, 1'b1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b1);
            tick();
            exp_sat = (i > 3) ? 2'd3 : 2'(i);
            vectors++;
            if (s_err_cnt !== exp_sat) begin miscompares++; $display("[TB] FAIL sat_cnt_%0d: got %0d want %0d", i, s_err_cnt, exp_sat); end
            applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 10'h000, T_IDLE, 1'b1);
        tick();
        exp_cnt = 8'd5;
        vectors++;
        if (err_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL wide_cnt: got %0d want %0d", err_cnt, exp_cnt); end
    endtask

    task automatic test_reset_in_err();
        logic [20:0] exp;
        applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b1);
        tick();
        exp = {10'h000, D_ERR1, 8'd6};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL rst_pre_err1: got %h want %h", obs, exp); end
        applyStimulus(1'b1, 10'h000, T_NONSEQ, 1'b0);
        tick();
        exp = {10'h000, D_IDLE, 8'd0};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL rst_in_err1: got %h want %h", obs, exp); end
        applyStimulus(1'b0, 10'h000, T_IDLE, 1'b1);
        tick();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL rst_no_error: got %h want %h", obs, exp); end
        // reset while in ERR2 with a pending error request must also win
        applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b1);
        tick();
        applyStimulus(1'b0, 10'h000, T_NONSEQ, 1'b0);
        tick();
        applyStimulus(1'b1, 10'b0000000110, T_NONSEQ, 1'b1);
        tick();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("[TB] FAIL rst_in_err2: got %h want %h", obs, exp); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_valid_decode();
        test_miss_error();
        test_conflict();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_reset_in_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_dp_sel.md
AHB_DP_SEL -- requirements
Module: ahb_dp_sel

Interface
REQ-001 Parameter NS, default 10, number of decoded slaves; width of the address-phase and data-phase select vectors.
REQ-002 Parameter CW, default 8, width of the saturating error counter.
REQ-003 hclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 hreset  input  1  reset; synchronous, active-high.
REQ-005 htrans  input  2  master address-phase transfer type; bit 1 set means NONSEQ or SEQ.
REQ-006 hready  input  1  combined bus HREADY, fed back from the response mux; 1 means the current address phase is accepted.
REQ-007 hsel_ap  input  NS  address-phase decoder select, expected one-hot or all-zero.
REQ-008 dsel  output  NS  registered data-phase select; drives the response-mux select inputs sel0..sel(NS-1).
REQ-009 dflt_sel  output  1  registered data-phase select of the internal default slave.
REQ-010 dflt_hreadyout  output  1  default-slave HREADYOUT, already ANDed with dflt_sel.
REQ-011 dflt_hresp  output  1  default-slave HRESP, already ANDed with dflt_sel.
REQ-012 err_cnt  output  CW  count of ERROR responses issued; saturates at all-ones.

Function
REQ-013 Capture: on a rising edge with hready=1, the block SHALL register the current address phase; with hready=0, dsel, dflt_sel and the captured error flag SHALL hold.
REQ-014 Valid decode: if hsel_ap has exactly one bit set, dsel SHALL load hsel_ap and dflt_sel SHALL load 0, regardless of htrans.
REQ-015 Decode miss: if hsel_ap is all-zero, dsel SHALL load 0 and dflt_sel SHALL load 1.
REQ-016 Decode conflict: if hsel_ap has two or more bits set, dsel SHALL load 0 and dflt_sel SHALL load 1, so that no slave drives the mux.
REQ-017 Error request: a decode miss or conflict captured with htrans[1]=1 SHALL start an ERROR response; with htrans[1]=0 (IDLE/BUSY), the default slave SHALL give a zero-wait OKAY.
REQ-018 The default-slave FSM SHALL have exactly three states: IDLE, ERR1 and ERR2.
REQ-019 IDLE: hreadyout=1, hresp=0; on a capture with an error request, go to ERR1; otherwise stay in IDLE.
REQ-020 ERR1: hreadyout=0, hresp=1; go unconditionally to ERR2 on the next edge (hready is ignored).
REQ-021 ERR2: hreadyout=1, hresp=1; the next address phase is captured on this edge; go to ERR1 on an error request, otherwise to IDLE.
REQ-022 Back-to-back errors: a continuous stream of error requests SHALL produce an ERR1,ERR2,ERR1,ERR2 sequence with no IDLE cycle between them.
REQ-023 The master may change htrans during ERR1; because hready=0 in ERR1, no capture SHALL occur there.
REQ-024 dflt_hreadyout SHALL equal the FSM hreadyout AND dflt_sel; dflt_hresp SHALL equal the FSM hresp AND dflt_sel.
REQ-025 Latency: dsel and dflt_sel SHALL change exactly one cycle after the accepting edge, with no combinational path from hsel_ap or htrans to any output.
REQ-026 err_cnt SHALL increment by 1 on each entry to ERR1 and SHALL hold at 2^CW-1 once reached (no wrap).
REQ-027 When dflt_sel=1, at most one bit of {dsel, dflt_sel} SHALL be set in any cycle, and dsel SHALL be 0.

Reset
REQ-028 With hreset=1 at an edge: dsel=0, dflt_sel=1, FSM=IDLE, err_cnt=0; so dflt_hreadyout=1 and dflt_hresp=0, and the combined hready is 1.
REQ-029 hreset SHALL take priority over capture and over every FSM transition, including a reset asserted in ERR1 or ERR2; no ERROR cycle SHALL follow reset.

Verification
REQ-030 Reset, then hsel_ap=10'b0000001000, htrans=NONSEQ, hready=1 -> next cycle dsel=10'b0000001000, dflt_sel=0, dflt_hreadyout=0, dflt_hresp=0.
REQ-031 hsel_ap=0, htrans=NONSEQ, accepted -> cycle+1: dflt_hreadyout=0, dflt_hresp=1; cycle+2: dflt_hreadyout=1, dflt_hresp=1; cycle+3 with IDLE/valid decode: hresp=0; err_cnt=1.
REQ-032 hsel_ap=10'b0000000011, htrans=SEQ -> dsel=0, dflt_sel=1, two-cycle ERROR as above; hsel_ap=0 with htrans=IDLE -> dflt_hreadyout=1, dflt_hresp=0, err_cnt unchanged.
REQ-033 hready held at 0 for 3 cycles while hsel_ap changes from 10'b0000000001 to 10'b1000000000 -> dsel stays 10'b0000000001 until the first edge with hready=1.
REQ-034 Three consecutive NONSEQ misses -> state sequence ERR1,ERR2,ERR1,ERR2,ERR1,ERR2 then IDLE; err_cnt=3. With CW=2 and 5 misses -> err_cnt saturates at 3.
REQ-035 hreset pulsed during ERR1 -> next cycle FSM=IDLE, dflt_sel=1, dflt_hreadyout=1, dflt_hresp=0, dsel=0, err_cnt=0.
